// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer
//   Single-command initiator for a 32x32 register file. Accepts one
//   register-to-register command, reads both sources, computes a result,
//   writes it back (except CMPEQ) and returns result/flags on a response
//   channel. Fixed latency: accept at edge N, rsp_valid during cycle N+4.
//
// Ports
//   clk, reset                  clock, async active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op/rs1/rs2/rd/imm       command fields (imm used by LI only)
//   ReadReg1/2, ReadData1/2     register-file read ports
//   WriteReg/WriteData/RegWrite register-file write port
//   rsp_valid/rsp_ready         response handshake
//   rsp_result/zero/carry       response payload
//   op_count                    completed responses, wraps
module regfile_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [15:0]       cmd_imm,
  output logic [ADDR_W-1:0] ReadReg1,
  output logic [ADDR_W-1:0] ReadReg2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam logic [2:0] OP_LI    = 3'b110;
  localparam logic [2:0] OP_CMPEQ = 3'b111;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, RESP} state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic [15:0]       imm;
  } cmd_t;

  state_t            state, next_state;
  cmd_t              cmd_q;
  logic [DATA_W-1:0] opa_q, opb_q;
  logic [DATA_W-1:0] res_q;
  logic              zero_q, carry_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [DATA_W:0]   sum, diff;
  logic [DATA_W-1:0] res_d;
  logic              carry_d;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    RegWrite   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) next_state = READ;
      end
      READ:  next_state = EXEC;
      EXEC:  next_state = WRITE;
      WRITE: begin
        // CMPEQ still passes through WRITE so latency never depends on op
        RegWrite   = (cmd_q.op != OP_CMPEQ);
        next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // ---------------- ALU ----------------
  // 33-bit add/sub: top bit is carry-out for ADD, borrow for SUB
  always_comb begin
    sum     = {1'b0, opa_q} + {1'b0, opb_q};
    diff    = {1'b0, opa_q} - {1'b0, opb_q};
    res_d   = '0;
    carry_d = 1'b0;
    case (cmd_q.op)
      OP_ADD:   begin res_d = sum[DATA_W-1:0];  carry_d = sum[DATA_W];  end
      OP_SUB:   begin res_d = diff[DATA_W-1:0]; carry_d = diff[DATA_W]; end
      OP_AND:   res_d = opa_q & opb_q;
      OP_OR:    res_d = opa_q | opb_q;
      OP_XOR:   res_d = opa_q ^ opb_q;
      OP_SLT:   res_d = {{(DATA_W-1){1'b0}}, ($signed(opa_q) < $signed(opb_q))};
      OP_LI:    res_d = {{(DATA_W-16){cmd_q.imm[15]}}, cmd_q.imm};
      OP_CMPEQ: res_d = {{(DATA_W-1){1'b0}}, (opa_q == opb_q)};
      default:  res_d = '0;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (cmd_valid && cmd_ready)
        cmd_q <= '{op: cmd_op, rs1: cmd_rs1, rs2: cmd_rs2, rd: cmd_rd, imm: cmd_imm};
      if (state == READ) begin
        opa_q <= ReadData1;
        opb_q <= ReadData2;
      end
      if (state == EXEC) begin
        res_q   <= res_d;
        zero_q  <= (res_d == '0);
        carry_q <= carry_d;
      end
      if (rsp_valid && rsp_ready)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Addresses track the latched command; they only matter in READ/WRITE
  assign ReadReg1   = cmd_q.rs1;
  assign ReadReg2   = cmd_q.rs2;
  assign WriteReg   = cmd_q.rd;
  assign WriteData  = res_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_carry  = carry_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
module tb_regfile_op_sequencer;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SLT = 3'd5, LI = 3'd6, CMPEQ = 3'd7;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [4:0]  cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
  logic [15:0] cmd_imm = '0;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg;
  logic [31:0] ReadData1, ReadData2, WriteData;
  logic        RegWrite, rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_carry;
  logic [15:0] op_count;

  regfile_op_sequencer #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Register file owned by the bench; contents survive DUT reset
  logic [31:0] rf [32];
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + i;
    forever begin
      @(posedge clk);
      if (RegWrite) rf[WriteReg] <= WriteData;
    end
  end
  assign ReadData1 = rf[ReadReg1];
  assign ReadData2 = rf[ReadReg2];

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] result;
    logic        zero, carry, writes;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mrf [32];
  int n_checks = 0, n_pass = 0;
  int mcount = 0, wr_seen = 0, wr_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Architectural meaning of each opcode
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, b,
                                 input logic [15:0] imm, input logic [4:0] rd);
    exp_t e;
    e.rd = rd; e.carry = 1'b0; e.writes = 1'b1; e.result = '0;
    case (op)
      ADD:   begin e.result = a + b; e.carry = (e.result < a); end
      SUB:   begin e.result = a - b; e.carry = (a < b); end
      AND_:  e.result = a & b;
      OR_:   e.result = a | b;
      XOR_:  e.result = a ^ b;
      SLT:   e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      LI:    e.result = {{16{imm[15]}}, imm};
      default: begin e.result = (a == b) ? 32'd1 : 32'd0; e.writes = 1'b0; end
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  // Per-cycle compare against the in-flight expectation
  always @(negedge clk) begin
    if (!reset) begin
      check("op_count", 32'(op_count), 32'(16'(mcount)));
      if (RegWrite) begin
        wr_seen++;
        if (q.size() == 0) check("stray RegWrite", 32'd1, 32'd0);
        else begin
          check("WriteReg", 32'(WriteReg), 32'(q[0].rd));
          check("write allowed", 32'd1, 32'(q[0].writes));
          check("WriteData", WriteData, q[0].result);
        end
      end
      if (rsp_valid) begin
        if (q.size() == 0) check("stray rsp_valid", 32'd1, 32'd0);
        else begin
          check("rsp_result", rsp_result, q[0].result);
          check("rsp_zero", 32'(rsp_zero), 32'(q[0].zero));
          check("rsp_carry", 32'(rsp_carry), 32'(q[0].carry));
        end
      end
    end
  end

  task automatic drive_cmd(input logic [2:0] op, input logic [4:0] rs1, rs2, rd,
                           input logic [15:0] imm);
    exp_t e;
    e = model(op, mrf[rs1], mrf[rs2], imm, rd);
    if (e.writes) mrf[rd] = e.result;
    wr_exp += int'(e.writes);
    q.push_back(e);
    cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_imm = imm;
    cmd_valid = 1'b1;
  endtask

  task automatic wait_accept(output int waited);
    waited = 0;
    while (!cmd_ready && waited < 20) begin @(negedge clk); waited++; end
    if (!cmd_ready) check("accept timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, output logic [31:0] res, output logic z, c);
    int lat, w0;
    lat = 0;
    if (hold > 0) rsp_ready = 1'b0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    check("rsp latency", 32'(lat), 32'd4);
    res = rsp_result; z = rsp_zero; c = rsp_carry; w0 = wr_seen;
    for (int i = 0; i < hold; i++) begin
      check("held rsp_valid", 32'(rsp_valid), 32'd1);
      check("held rsp_result", rsp_result, res);
      check("held cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    if (hold > 0) check("no write while held", 32'(wr_seen), 32'(w0));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    if (q.size() != 0) void'(q.pop_front());
    mcount++;
  endtask

  task automatic run(input logic [2:0] op, input logic [4:0] rs1, rs2, rd,
                     input logic [15:0] imm, output logic [31:0] res, output logic z, c);
    int w;
    drive_cmd(op, rs1, rs2, rd, imm);
    wait_accept(w);
    wait_rsp(0, res, z, c);
    check("write count", 32'(wr_seen), 32'(wr_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, old;
    logic z, c;
    int w;
    for (int i = 0; i < 32; i++) mrf[i] = 32'hA000_0000 + i;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("cmd_ready after reset", 32'(cmd_ready), 32'd1);

    // Reset mid-cycle while busy in READ and another command is offered
    old = mrf[5];
    drive_cmd(ADD, 5'd3, 5'd4, 5'd5, 16'h0);
    wait_accept(w);
    @(negedge clk);
    check("ReadReg1 in READ", 32'(ReadReg1), 32'd3);
    cmd_valid = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("reset RegWrite", 32'(RegWrite), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset op_count", 32'(op_count), 32'd0);
    check("reset ReadReg1", 32'(ReadReg1), 32'd0);
    check("reset ReadReg2", 32'(ReadReg2), 32'd0);
    check("reset WriteReg", 32'(WriteReg), 32'd0);
    check("reset WriteData", WriteData, 32'd0);
    check("reset rsp_result", rsp_result, 32'd0);
    q.delete(); mrf[5] = old; wr_exp--;
    cmd_valid = 1'b0;
    @(negedge clk); reset = 1'b0; #1;
    check("cmd_ready after deassert", 32'(cmd_ready), 32'd1);

    // LI, LI, ADD with carry
    run(LI, 5'd0, 5'd0, 5'd3, 16'h0005, r, z, c);
    check("LI 5", r, 32'h0000_0005);
    run(LI, 5'd0, 5'd0, 5'd4, 16'hFFFF, r, z, c);
    check("LI FFFF sign-ext", r, 32'hFFFF_FFFF);
    run(ADD, 5'd3, 5'd4, 5'd5, 16'h0, r, z, c);
    check("ADD result", r, 32'h0000_0004);
    check("ADD carry", 32'(c), 32'd1);
    check("r3", rf[3], 32'h0000_0005);
    check("r4", rf[4], 32'hFFFF_FFFF);
    check("r5", rf[5], 32'h0000_0004);
    check("op_count 3", 32'(op_count), 32'd3);

    // SUB zero / borrow
    run(SUB, 5'd3, 5'd3, 5'd6, 16'h0, r, z, c);
    check("SUB zero result", r, 32'd0);
    check("SUB zero flag", 32'(z), 32'd1);
    check("SUB no borrow", 32'(c), 32'd0);
    run(SUB, 5'd3, 5'd4, 5'd6, 16'h0, r, z, c);
    check("SUB 5-(-1)", r, 32'h0000_0006);
    check("SUB borrow", 32'(c), 32'd1);

    // CMPEQ never writes; SLT is signed
    w = wr_seen;
    run(CMPEQ, 5'd3, 5'd3, 5'd7, 16'h0, r, z, c);
    check("CMPEQ result", r, 32'd1);
    check("CMPEQ no write", 32'(wr_seen), 32'(w));
    check("r7 unchanged", rf[7], 32'hA000_0007);
    run(SLT, 5'd4, 5'd3, 5'd8, 16'h0, r, z, c);
    check("SLT -1<5", r, 32'd1);

    // Backpressure with a second command pending
    drive_cmd(XOR_, 5'd3, 5'd4, 5'd8, 16'h0);
    wait_accept(w);
    drive_cmd(OR_, 5'd3, 5'd5, 5'd10, 16'h0);
    wait_rsp(10, r, z, c);
    check("XOR result", r, 32'hFFFF_FFFA);
    wait_accept(w);
    check("pending accepted at once", 32'(w), 32'd0);
    wait_rsp(0, r, z, c);
    check("OR result", r, 32'h0000_0005);
    check("write count bp", 32'(wr_seen), 32'(wr_exp));
    check("r10", rf[10], 32'h0000_0005);

    // Reset during WRITE abandons the write
    old = mrf[9];
    drive_cmd(ADD, 5'd3, 5'd4, 5'd9, 16'h0);
    wait_accept(w);
    repeat (3) @(negedge clk);
    check("RegWrite in WRITE", 32'(RegWrite), 32'd1);
    #1 reset = 1'b1; mcount = 0;
    #1;
    check("RegWrite drops", 32'(RegWrite), 32'd0);
    check("rsp_valid after reset", 32'(rsp_valid), 32'd0);
    check("op_count cleared", 32'(op_count), 32'd0);
    q.delete(); mrf[9] = old;
    @(negedge clk); reset = 1'b0; #1;
    check("idle after reset", 32'(cmd_ready), 32'd1);
    check("r9 kept", rf[9], 32'hA000_0009);

    // Recovery plus sign-extension and carry boundaries
    run(LI, 5'd0, 5'd0, 5'd9, 16'h8000, r, z, c);
    check("LI 8000", r, 32'hFFFF_8000);
    run(AND_, 5'd9, 5'd4, 5'd11, 16'h0, r, z, c);
    check("AND result", r, 32'hFFFF_8000);
    run(ADD, 5'd9, 5'd9, 5'd12, 16'h0, r, z, c);
    check("ADD wrap", r, 32'hFFFF_0000);
    check("ADD wrap carry", 32'(c), 32'd1);
    check("r12", rf[12], 32'hFFFF_0000);
    check("op_count 3 again", 32'(op_count), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Initiator that drives the read and write ports of the 32x32 register file.
- Accepts one register-to-register command at a time over a valid/ready handshake and reads two source registers.
- Computes a 32-bit result, writes it back to the destination register, then returns the result and flags over a valid/ready response channel.
- Sits between the instruction/command front end and the register file; it is the only master of the register-file ports.

Parameters:
- DATA_W, 32, register and result width.
- ADDR_W, 5, register index width (32 registers).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  opcode (encoding below).
- cmd_rs1  input  ADDR_W  source register 1 index.
- cmd_rs2  input  ADDR_W  source register 2 index.
- cmd_rd  input  ADDR_W  destination register index.
- cmd_imm  input  16  immediate, used by LI only.
- ReadReg1  output  ADDR_W  register-file read address 1.
- ReadReg2  output  ADDR_W  register-file read address 2.
- ReadData1  input  DATA_W  register-file read data 1 (combinational from ReadReg1).
- ReadData2  input  DATA_W  register-file read data 2.
- WriteReg  output  ADDR_W  register-file write address.
- WriteData  output  DATA_W  register-file write data.
- RegWrite  output  1  register-file write enable; the register file writes on the clk rising edge while this is high.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  DATA_W  computed result.
- rsp_zero  output  1  rsp_result == 0.
- rsp_carry  output  1  ADD carry-out or SUB borrow; 0 for all other ops.
- op_count  output  CNT_W  number of completed responses, wraps modulo 2^CNT_W.

Behaviour:
- Opcodes:
  - 000 ADD: rs1+rs2.
  - 001 SUB: rs1-rs2.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: signed rs1<rs2 gives 1, else 0.
  - 110 LI: sign-extended cmd_imm.
  - 111 CMPEQ: {31'b0, rs1==rs2}, no write-back.
- FSM states: IDLE, READ, EXEC, WRITE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op/rs1/rs2/rd/imm and go to READ.
- READ:
  - ReadReg1/ReadReg2 driven from the latched rs1/rs2.
  - At the end of the cycle, capture ReadData1/ReadData2 into operand registers; go to EXEC.
- EXEC:
  - Compute the result with a 33-bit ADD/SUB for carry/borrow.
  - Register result, zero and carry; go to WRITE.
- WRITE:
  - WriteReg=rd, WriteData=result, RegWrite=1 for exactly this one cycle.
  - For CMPEQ, RegWrite stays 0 but the state is still traversed, so latency is constant.
  - Go to RESP.
- RESP:
  - rsp_valid=1 and the rsp_* values are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, op_count increments and the FSM returns to IDLE.
- Latency: accept edge at cycle N, rsp_valid high during cycle N+4. Minimum command spacing is 5 cycles (next accept at N+5 with rsp_ready held high).
- Back-to-back read-after-write to the same register needs no forwarding: the write completes at the end of WRITE, before the next command's READ.
- cmd_ready is low in every state except IDLE. Commands presented while busy are not accepted and must be held by the source.
- RegWrite is high only in WRITE with a writing opcode, never in any other state.
- All outputs are registered or decoded only from state and internal registers. There is no combinational path from cmd_* or rsp_ready to any output.
- Read addresses are held at the last latched values outside READ. WriteReg/WriteData are held at the last values; they are don't-care while RegWrite=0.
- Reset (asynchronous, any state, including mid-WRITE):
  - FSM goes to IDLE immediately.
  - RegWrite=0, rsp_valid=0, cmd_ready=1 once reset deasserts.
  - All address, data and rsp outputs go to 0; op_count goes to 0; operand registers are cleared.
  - An in-flight write is abandoned if reset asserts before its clock edge.
- Arithmetic: ADD/SUB wrap modulo 2^32. SLT compares two's complement. LI sign-extends bit 15.

Test Plan:
- Reset:
  - Stimulus: assert reset mid-cycle with cmd_valid=1.
  - Required: RegWrite=0, rsp_valid=0, op_count=0, all address/data outputs 0 immediately; after deassert cmd_ready=1.
- LI then ADD:
  - Stimulus: LI rd=3 imm=16'h0005; LI rd=4 imm=16'hFFFF; ADD rs1=3 rs2=4 rd=5.
  - Required: r3=5, r4=32'hFFFFFFFF; ADD result=32'h00000004 with rsp_carry=1; r5 reads back 4; op_count=3.
- SUB zero and borrow:
  - Stimulus: SUB rs1=3 rs2=3.
  - Required: result 0, rsp_zero=1, rsp_carry=0.
  - Stimulus: SUB rs1=3 rs2=4.
  - Required: result 32'h00000006, rsp_carry=1.
- CMPEQ and SLT:
  - Stimulus: CMPEQ rs1=3 rs2=3 rd=7.
  - Required: result 1; RegWrite never high; r7 unchanged.
  - Stimulus: SLT rs1=4 rs2=3.
  - Required: result 1, because -1 < 5.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 10 cycles with a second cmd_valid pending.
  - Required: rsp_* stable, cmd_ready=0, no second RegWrite; release gives exactly one handshake, then the next command is accepted in IDLE.
- Reset mid-op:
  - Stimulus: assert reset while in WRITE for ADD rd=9.
  - Required: RegWrite drops immediately, r9 keeps its old value, FSM in IDLE, op_count=0.
